// File: rtl/shift_ser_ctrl_pkg.sv
// Shared types and defaults for the serializer controller slice.
// Holds the FSM state encoding and the default word/counter sizes.
package shift_ser_pkg;

    localparam int WIDTH_DEFAULT  = 4;
    localparam int WCNT_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Last bit of a word is reached when exactly one bit remains.
    function automatic logic is_last_bit(input logic [31:0] remaining);
        return (remaining == 32'd1);
    endfunction

endpackage

// File: rtl/shift_ser_ctrl_if.sv
// Word-in / bit-out handshake bundle of the serializer controller.
// The slave side is the controller; the master side is the producer/consumer pair.
interface shift_ser_ctrl_if
    import shift_ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_bit;
    logic             ser_last;

    modport master (
        output in_valid,
        output in_data,
        output ser_ready,
        input  in_ready,
        input  ser_valid,
        input  ser_bit,
        input  ser_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  ser_ready,
        output in_ready,
        output ser_valid,
        output ser_bit,
        output ser_last
    );

endinterface

// File: rtl/shift_ser_ctrl_shift_reg.sv
// WIDTH-bit right shift register with zero fill.
// Synchronous clear beats parallel load, which beats shift.
module shift_reg_n
    import shift_ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic             ena,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Shift register storage: clear, load, shift or hold
    always_ff @(posedge clk) begin
        if (areset) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= data;
        end else if (ena) begin
            q_r <= {1'b0, q_r[WIDTH-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/shift_ser_ctrl.sv
// Serializer controller: accepts parallel words and streams them LSB-first
// with independent valid/ready on both sides and no bubble between words.
module shift_ser_ctrl
    import shift_ser_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int CNT_W  = $clog2(WIDTH + 1),
    parameter int WCNT_W = WCNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               flush,
    shift_ser_ctrl_if.slave    bus,
    output logic               busy,
    output logic [WCNT_W-1:0]  words_sent
);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1'b1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [CNT_W-1:0]    bit_cnt_nxt_s;
    logic [WCNT_W-1:0]   words_sent_r;
    logic [WCNT_W-1:0]   words_nxt_s;

    logic                shifting_s;
    logic                last_s;
    logic                bit_hs_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                sr_clr_s;
    logic [WIDTH-1:0]    sr_q_s;
    logic                sr_unused_s;

    assign shifting_s = (state_r == SHIFT);
    assign last_s     = is_last_bit(32'(bit_cnt_r));
    assign bit_hs_s   = shifting_s & bus.ser_ready;

    // Ready is withheld while reset or flush is pending so no word is lost to the clear.
    assign in_ready_s = ~areset & ~flush &
                        ((state_r == IDLE) | (shifting_s & last_s & bus.ser_ready));
    assign accept_s   = in_ready_s & bus.in_valid;
    assign sr_clr_s   = areset | flush;

    shift_reg_n #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk    (clk),
        .areset (sr_clr_s),
        .load   (accept_s),
        .ena    (bit_hs_s),
        .data   (bus.in_data),
        .q      (sr_q_s)
    );

    // Only q[0] leaves the block; upper bits just move toward it.
    assign sr_unused_s = ^sr_q_s[WIDTH-1:1];

    // Next-state, remaining-bit count and word count
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        words_nxt_s   = words_sent_r;
        if (flush) begin
            state_nxt_s   = IDLE;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s   = SHIFT;
                        bit_cnt_nxt_s = CNT_FULL;
                    end else begin
                        state_nxt_s   = IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_hs_s && last_s) begin
                        words_nxt_s = words_sent_r + WCNT_ONE;
                        if (accept_s) begin
                            state_nxt_s   = SHIFT;
                            bit_cnt_nxt_s = CNT_FULL;
                        end else begin
                            state_nxt_s   = IDLE;
                            bit_cnt_nxt_s = bit_cnt_r - CNT_ONE;
                        end
                    end else if (bit_hs_s) begin
                        bit_cnt_nxt_s = bit_cnt_r - CNT_ONE;
                    end else begin
                        state_nxt_s   = SHIFT;
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            words_sent_r <= {WCNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            words_sent_r <= words_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.ser_valid = shifting_s;
    assign bus.ser_bit   = sr_q_s[0];
    assign bus.ser_last  = shifting_s & last_s;
    assign busy          = shifting_s;
    assign words_sent    = words_sent_r;

endmodule
